// File: rtl/sdram_ctrl_refsched.sv
// SDRAM refresh scheduler: periodic refresh credits, power-up refresh burst,
// and normal/urgent refresh requests toward the command sequencer.
module sdram_ctrl_refsched #(
    parameter int CNT_W     = 13,
    parameter int PEND_W    = 4,
    parameter int MAX_PEND  = 8,
    parameter int URGENT_TH = 6,
    parameter int INIT_REFS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  ref_interval,
    input  logic              ref_en,
    input  logic              init_start,
    input  logic              ref_ack,
    input  logic              ovf_clr,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic [PEND_W-1:0] ref_pending,
    output logic              init_done,
    output logic              ref_ovf,
    output logic              ack_err
);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [PEND_W-1:0]   pending, pending_n;
    logic                ovf, ovf_n;
    logic                aerr, aerr_n;
    logic                done, done_n;
    logic                counting, tick, dec, empty, full;

    assign empty    = (pending == '0);
    assign full     = (pending == PEND_W'(MAX_PEND));
    assign dec      = ref_ack & ~empty;
    assign counting = (state == RUN) & ref_en & (ref_interval != '0);
    // >= rather than == so that lowering the interval mid-count ticks at once
    assign tick     = counting & (count >= ref_interval - CNT_W'(1));

    always_comb begin
        state_n   = state;
        pending_n = pending;
        done_n    = 1'b0;
        count_n   = '0;
        if (counting && !tick)
            count_n = count + CNT_W'(1);
        case (state)
            IDLE: begin
                if (init_start) begin
                    pending_n = PEND_W'(INIT_REFS);
                    state_n   = INIT;
                end
            end
            INIT: begin
                if (dec) begin
                    pending_n = pending - PEND_W'(1);
                    if (pending == PEND_W'(1)) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tick && !dec && !full)
                    pending_n = pending + PEND_W'(1);
                else if (dec && !tick)
                    pending_n = pending - PEND_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as ovf_clr takes priority.
    always_comb begin
        ovf_n  = ovf;
        aerr_n = aerr;
        if (ovf_clr) begin
            ovf_n  = 1'b0;
            aerr_n = 1'b0;
        end
        if (tick && !dec && full)
            ovf_n = 1'b1;
        if (ref_ack && empty)
            aerr_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
            aerr    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            pending <= pending_n;
            ovf     <= ovf_n;
            aerr    <= aerr_n;
            done    <= done_n;
        end
    end

    assign ref_req     = ~empty;
    assign ref_urgent  = ((state == INIT) & ~empty) | (pending >= PEND_W'(URGENT_TH));
    assign ref_pending = pending;
    assign init_done   = done;
    assign ref_ovf     = ovf;
    assign ack_err     = aerr;

endmodule

// File: tb/tb_sdram_ctrl_refsched.sv
// Directed bench for sdram_ctrl_refsched with hand-computed expectations.
module tb_sdram_ctrl_refsched;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] ref_interval;
    logic        ref_en, init_start, ref_ack, ovf_clr;
    logic        ref_req, ref_urgent, init_done, ref_ovf, ack_err;
    logic [3:0]  ref_pending;

    int checks = 0;
    int errors = 0;

    sdram_ctrl_refsched dut (
        .clk(clk), .rst(rst), .ref_interval(ref_interval), .ref_en(ref_en),
        .init_start(init_start), .ref_ack(ref_ack), .ovf_clr(ovf_clr),
        .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_pending(ref_pending),
        .init_done(init_done), .ref_ovf(ref_ovf), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(ref_req), 0);
        check({tag, "_urg"}, 32'(ref_urgent), 0);
        check({tag, "_pend"}, 32'(ref_pending), 0);
        check({tag, "_done"}, 32'(init_done), 0);
        check({tag, "_ovf"}, 32'(ref_ovf), 0);
        check({tag, "_aerr"}, 32'(ack_err), 0);
    endtask

    initial begin
        int exp_p;
        rst = 1'b0; ref_interval = '0; ref_en = 1'b0;
        init_start = 1'b0; ref_ack = 1'b0; ovf_clr = 1'b0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b1;
        step();

        // Power-up burst: 8 acks spaced 3 clocks apart
        init_start = 1'b1; step(); init_start = 1'b0;
        check("init_pend", 32'(ref_pending), 8);
        check("init_urg", 32'(ref_urgent), 1);
        for (int i = 1; i <= 8; i++) begin
            ref_ack = 1'b1; step(); ref_ack = 1'b0;
            check("burst_pend", 32'(ref_pending), 32'(8 - i));
            check("burst_done", 32'(init_done), (i == 8) ? 1 : 0);
            if (i < 8) check("burst_urg", 32'(ref_urgent), 1);
            step(); step();
        end
        check("done_once", 32'(init_done), 0);
        check("run_req", 32'(ref_req), 0);
        check("run_urg", 32'(ref_urgent), 0);
        check("run_aerr", 32'(ack_err), 0);

        // Periodic ticking, interval 10, through saturation
        ref_interval = 13'd10; ref_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            repeat (9) step();
            exp_p = (k - 1 > 8) ? 8 : k - 1;
            check("tick_pre", 32'(ref_pending), 32'(exp_p));
            step();
            exp_p = (k > 8) ? 8 : k;
            check("tick_pend", 32'(ref_pending), 32'(exp_p));
            check("tick_urg", 32'(ref_urgent), (exp_p >= 6) ? 1 : 0);
            check("tick_ovf", 32'(ref_ovf), (k == 9) ? 1 : 0);
        end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_clr", 32'(ref_ovf), 0);

        // Drain to 3 with ticking paused, then tick and ack on the same edge
        ref_en = 1'b0;
        repeat (5) begin ref_ack = 1'b1; step(); end
        ref_ack = 1'b0;
        check("drain_pend", 32'(ref_pending), 3);
        check("drain_urg", 32'(ref_urgent), 0);
        ref_en = 1'b1;
        repeat (9) step();
        check("pre_coll", 32'(ref_pending), 3);
        ref_ack = 1'b1; step(); ref_ack = 1'b0;
        check("coll_pend", 32'(ref_pending), 3);
        check("coll_ovf", 32'(ref_ovf), 0);

        // Last credit acked twice back-to-back
        ref_en = 1'b0;
        ref_ack = 1'b1; step(); step(); ref_ack = 1'b0;
        check("one_pend", 32'(ref_pending), 1);
        ref_ack = 1'b1; step();
        check("last_pend", 32'(ref_pending), 0);
        check("last_req", 32'(ref_req), 0);
        check("last_aerr", 32'(ack_err), 0);
        step(); ref_ack = 1'b0;
        check("dbl_aerr", 32'(ack_err), 1);
        check("dbl_pend", 32'(ref_pending), 0);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("aerr_clr", 32'(ack_err), 0);

        // Interval lowered mid-count, then pause and resume
        ref_interval = 13'd1000; ref_en = 1'b1;
        repeat (200) step();
        check("long_pend", 32'(ref_pending), 0);
        ref_interval = 13'd5; step();
        check("lower_tick", 32'(ref_pending), 1);
        repeat (4) step();
        check("p5_pre", 32'(ref_pending), 1);
        step();
        check("p5_tick", 32'(ref_pending), 2);
        ref_en = 1'b0;
        repeat (7) step();
        check("frozen", 32'(ref_pending), 2);
        check("frozen_req", 32'(ref_req), 1);
        ref_en = 1'b1;
        repeat (4) step();
        check("resume_pre", 32'(ref_pending), 2);
        step();
        check("resume_tick", 32'(ref_pending), 3);

        // Reset in the middle of the power-up burst
        ref_en = 1'b0;
        rst = 1'b0; step(); rst = 1'b1;
        init_start = 1'b1; step(); init_start = 1'b0;
        repeat (4) begin ref_ack = 1'b1; step(); end
        ref_ack = 1'b0;
        check("mid_pend", 32'(ref_pending), 4);
        check("mid_urg", 32'(ref_urgent), 1);
        rst = 1'b0; ref_ack = 1'b1; step();
        check_all_zero("midrst");
        rst = 1'b1; step(); ref_ack = 1'b0;
        check("post_aerr", 32'(ack_err), 1);
        check("post_req", 32'(ref_req), 0);
        check("post_pend", 32'(ref_pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
